// File: rtl/jlsemi_clk_gate_pkg.sv
//------------------------------------------------------------------------------
// Module      : jlsemi_clk_gate_pkg
// Description : Shared state encoding and widths for the clock-gate controller
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jlsemi_clk_gate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } gate_state_t;

  localparam int GATE_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/jlsemi_util_sat_cnt.sv
//------------------------------------------------------------------------------
// Module      : jlsemi_util_sat_cnt
// Description : Up counter that holds at all-ones; clr and rst return it to 0
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jlsemi_util_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/jlsemi_util_clk_gate_ctrl.sv
//------------------------------------------------------------------------------
// Module      : jlsemi_util_clk_gate_ctrl
// Description : Idle-timeout clock-gate controller driving ICG E/TE with a
//               request/acknowledge wake handshake and warm-up delay
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jlsemi_util_clk_gate_ctrl
  import jlsemi_clk_gate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_auto_en,
  input  logic [IDLE_W-1:0]     cfg_idle_thr,
  input  logic                  busy,
  input  logic                  wake_req,
  input  logic                  force_on,
  input  logic                  scan_mode,
  output logic                  clk_en,
  output logic                  clk_te,
  output logic                  wake_ack,
  output logic                  gated,
  output logic [GATE_CNT_W-1:0] gate_cnt
);

  localparam int                  C_WAKE_W    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [C_WAKE_W-1:0] C_WAKE_LAST = C_WAKE_W'(WAKE_CYC - 1);

  gate_state_t         r_state;
  gate_state_t         w_next_state;
  logic [C_WAKE_W-1:0] r_wake_cnt;
  logic                r_clk_en;
  logic [IDLE_W-1:0]   w_idle_cnt;
  logic                w_idle;
  logic                w_keep_on;
  logic                w_gate_evt;

  assign w_idle    = !busy && !wake_req;
  assign w_keep_on = !cfg_auto_en || force_on;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (w_idle && !w_keep_on && (w_idle_cnt >= cfg_idle_thr)) begin
          w_next_state = GATED;
        end
      end
      GATED: begin
        if (busy || wake_req || w_keep_on) begin
          w_next_state = WAKE;
        end
      end
      WAKE: begin
        // Warm-up runs to completion even if the requester goes away.
        if (r_wake_cnt == C_WAKE_LAST) begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_clk_en <= (w_next_state != GATED);
      if (r_state == GATED) begin
        r_wake_cnt <= '0;
      end else if (r_state == WAKE) begin
        r_wake_cnt <= r_wake_cnt + C_WAKE_W'(1);
      end
    end
  end

  assign w_gate_evt = (r_state == RUN) && (w_next_state == GATED);

  // Idle run length restarts on any activity and whenever RUN is (re)entered.
  jlsemi_util_sat_cnt #(
    .WIDTH (IDLE_W)
  ) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((r_state != RUN) || !w_idle),
    .inc ((r_state == RUN) && w_idle),
    .cnt (w_idle_cnt)
  );

  jlsemi_util_sat_cnt #(
    .WIDTH (GATE_CNT_W)
  ) u_gate_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (w_gate_evt),
    .cnt (gate_cnt)
  );

  assign clk_en   = r_clk_en;
  assign clk_te   = scan_mode;
  assign wake_ack = (r_state == RUN) && wake_req;
  assign gated    = (r_state == GATED);

endmodule

`default_nettype wire

// File: doc/jlsemi_util_clk_gate_ctrl.md
# jlsemi_util_clk_gate_ctrl

Automatic clock-gating controller that produces the enable (E) and test-enable (TE) inputs for a `jlsemi_cell_clk_gating_cell` instance. It watches downstream activity and stops the gated clock after a programmable number of idle cycles. A request/acknowledge handshake restarts the gated clock, and a fixed warm-up delay must elapse before the acknowledge is given. The block runs on the free-running clock upstream of the ICG and sits beside each gated domain in the ADC capture path.

## Interface
Parameters:
- `IDLE_W`, 8, width of the idle threshold and idle counter
- `WAKE_CYC`, 2, number of cycles the gated clock runs before `wake_ack` (must be ≥1)

Ports:
- `clk` input 1: free-running clock, the same clock that drives the ICG `CP`
- `rst` input 1: synchronous reset, active-high
- `cfg_auto_en` input 1: enables automatic gating; 0 keeps the clock on
- `cfg_idle_thr` input IDLE_W: number of idle cycles required before gating
- `busy` input 1: the gated domain has work in flight
- `wake_req` input 1: level request for a running clock; held until `wake_ack`
- `force_on` input 1: debug override, keeps the clock on
- `scan_mode` input 1: DFT mode
- `clk_en` output 1: drives ICG `E`; registered
- `clk_te` output 1: drives ICG `TE`; equals `scan_mode` (combinational pass-through)
- `wake_ack` output 1: clock is running and settled, `wake_req` is granted
- `gated` output 1: status, clock is currently stopped
- `gate_cnt` output 16: saturating count of gating events

## Operation
- States: RUN, GATED, WAKE. The state, `idle_cnt`, `wake_cnt` and `gate_cnt` are all registers.
- Idle condition, per cycle: `idle = !busy && !wake_req`.
- `keep_on = !cfg_auto_en || force_on`.

RUN:
- `idle_cnt` clears on any non-idle cycle.
- On an idle cycle, `idle_cnt` increments, saturating at all-ones.
- Transition to GATED when `idle && !keep_on && idle_cnt >= cfg_idle_thr`.
  - With `cfg_idle_thr=0`, the first idle cycle gates.
- On that transition, `gate_cnt` increments, saturating at 16'hFFFF.

GATED:
- Transition to WAKE when `busy || wake_req || keep_on`.
- `wake_cnt` loads 0.

WAKE:
- `wake_cnt` increments every cycle.
- When `wake_cnt == WAKE_CYC-1`, transition to RUN and clear `idle_cnt`.
- A drop of `wake_req` or `busy` during WAKE does not abort WAKE.

Outputs:
- `clk_en = (next_state != GATED)`, registered, so `clk_en` equals `state != GATED`.
- `wake_ack = (state == RUN) && wake_req`. It is combinational from the registered state and may stay high while `wake_req` is held.
- `gated = (state == GATED)`.
- `scan_mode` does not affect the FSM. The ICG is transparent through `TE`.

Reset values:
- state RUN
- `clk_en=1`, `gated=0`, `wake_ack=0`
- `idle_cnt=0`, `wake_cnt=0`, `gate_cnt=0`

Reset mid-operation: asserting `rst` in any state forces RUN and `clk_en=1` on the next edge. `gate_cnt` is cleared.

## Timing
- Gating latency:
  - The threshold condition is true in cycle t.
  - `clk_en=0` and `gated=1` from cycle t+1.
  - The ICG latch then removes the gated pulse in cycle t+1.
- Wake latency:
  - The wake event is seen in GATED in cycle t.
  - `clk_en=1` from cycle t+1.
  - RUN at cycle t+1+WAKE_CYC.
  - `wake_ack` is high at cycle t+1+WAKE_CYC if `wake_req` is still high.
- `wake_req` arriving in RUN: `wake_ack` is high in the same cycle (zero latency).
- Simultaneous events:
  - Threshold reached in the same cycle that `cfg_auto_en` falls or `force_on` rises: stay in RUN.
  - `busy` and `wake_req` together in GATED: a single WAKE pass.
- A change of `cfg_idle_thr` takes effect on the next comparison. `idle_cnt` is not reset.

## Structure
- Package `jlsemi_clk_gate_pkg` holds:
  - state encoding localparams: RUN=2'd0, GATED=2'd1, WAKE=2'd2
  - `GATE_CNT_W=16`
- Sub-module `jlsemi_util_sat_cnt` (parameter WIDTH; inputs clr, inc; output cnt) provides the saturating counter. It is instantiated for `idle_cnt` and `gate_cnt`.
- The parent domain instantiates `jlsemi_cell_clk_gating_cell` and connects `clk_en`→E, `clk_te`→TE, `clk`→CP. This block contains no clock-path cells.

## Test plan
- Reset then idle:
  - Stimulus: `cfg_auto_en=1`, `cfg_idle_thr=4`, `busy=0`, `wake_req=0`.
  - Required: the threshold is met in the fifth idle cycle after reset; `clk_en` falls the following cycle; `gate_cnt=1`; `gated=1`.
- Wake handshake:
  - Stimulus: in GATED with `WAKE_CYC=2`, raise `wake_req` at cycle t.
  - Required: `clk_en=1` at t+1; `wake_ack=1` at t+3; no ack before t+3.
- Busy glitch:
  - Stimulus: `cfg_idle_thr=4`; pulse `busy` for one cycle after 3 idle cycles.
  - Required: `idle_cnt` restarts; no gating until 5 further consecutive idle cycles.
- Overrides:
  - `force_on=1` or `cfg_auto_en=0` at the same cycle the threshold is met → stays in RUN, `clk_en` never drops.
  - `force_on` rising in GATED → WAKE, then RUN.
- Reset mid-gating:
  - Stimulus: assert `rst` for 1 cycle in GATED.
  - Required: next edge `clk_en=1`, `gated=0`, `gate_cnt=0`.
- Saturation:
  - `cfg_idle_thr=8'hFF`, long idle → gates after the `idle_cnt` saturation point.
  - Force `gate_cnt` to 16'hFFFE, gate twice → `gate_cnt` holds 16'hFFFF.
